pll_lock_sequencer: RTL and testbench

Consumer-side controller for the system PLL's `rst`/`locked` interface, running in the 10 MHz reference-clock domain. Drives the PLL reset, synchronizes and qualifies the asynchronous `locked` status, and holds the OFDM datapath in reset until lock has been stable for a programmed interval. On lock timeout it re-pulses the PLL reset with bounded retries. On loss of lock during operation it re-sequences.

---
 rtl/pll_lock_sequencer.sv | 116 +++++++++++
 tb/tb_pll_lock_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer in the refclk domain; holds the datapath in reset until lock is stable.
// Define PLL_LOCK_LOSS_CNT_EN to add the saturating lock_loss_cnt output.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 10000,
  parameter int STABLE_CYCLES  = 1000,
  parameter int MAX_RETRIES    = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] ST_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  MAX_R    = 4'(MAX_RETRIES);

  state_t      state;
  state_t      nxt;
  logic [15:0] cnt;
  logic        sync1;
  logic        locked_s;
  logic        retry_inc;

  // Next-state selection; lock on the timeout cycle wins over a retry.
  always_comb begin
    nxt       = state;
    retry_inc = 1'b0;
    unique case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          nxt = STABLE;
        end else if (cnt == TO_LAST) begin
          if (retry_cnt == MAX_R) begin
            nxt = FAULT;
          end else begin
            nxt       = RESET_PLL;
            retry_inc = 1'b1;
          end
        end
      end
      STABLE: begin
        if (!locked_s) nxt = WAIT_LOCK;
        else if (cnt == ST_LAST) nxt = RUN;
      end
      RUN: begin
        if (!locked_s) nxt = RESET_PLL;
      end
      FAULT: nxt = FAULT;
      default: nxt = RESET_PLL;
    endcase
  end

  // State, counter, synchronizer and outputs registered from the next state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      sync1     <= 1'b0;
      locked_s  <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
      state    <= nxt;
      cnt      <= (nxt != state) ? 16'd0 : cnt + 16'd1;
      pll_rst  <= (nxt == RESET_PLL);
      sys_rst  <= (nxt != RUN);
      ready    <= (nxt == RUN);
      fault    <= (nxt == FAULT);
      if (nxt == RUN && state != RUN) begin
        retry_cnt <= '0;
      end else if (retry_inc && retry_cnt != MAX_R) begin
        retry_cnt <= retry_cnt + 4'd1;
      end
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  // Count RUN exits caused by lock loss; only rst clears it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_loss_cnt <= '0;
    end else if (state == RUN && nxt == RESET_PLL
                 && lock_loss_cnt != 8'hff) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed table, hand sequences and
// randomized lock activity against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;

  localparam int P = 4;
  localparam int T = 40;
  localparam int S = 20;
  localparam int M = 3;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .MAX_RETRIES   (M)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .locked   (locked),
    .pll_rst  (pll_rst),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .fault    (fault),
    .retry_cnt(retry_cnt)
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  // Reference model: phase plus edges elapsed in that phase.
  localparam int RP = 0, WL = 1, ST = 2, RN = 3, FT = 4;
  int m_ph, m_since, m_tries, m_loss;
  bit m_q1, m_q2;

  task automatic go(input int ph);
    m_ph    = ph;
    m_since = 0;
  endtask

  task automatic model_step();
    bit ls;
    if (rst) begin
      m_ph = RP; m_since = 0; m_tries = 0; m_loss = 0;
      m_q1 = 0; m_q2 = 0;
      return;
    end
    ls = m_q2;
    m_q2 = m_q1;
    m_q1 = locked;
    m_since++;
    case (m_ph)
      RP: if (m_since == P) go(WL);
      WL: begin
        if (ls) go(ST);
        else if (m_since == T) begin
          if (m_tries == M) go(FT);
          else begin
            m_tries++;
            go(RP);
          end
        end
      end
      ST: begin
        if (!ls) go(WL);
        else if (m_since == S) begin
          m_tries = 0;
          go(RN);
        end
      end
      RN: begin
        if (!ls) begin
          if (m_loss < 255) m_loss++;
          go(RP);
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge refclk);
    model_step();
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string nm, input bit p, input bit s,
                     input bit r, input bit f, input logic [3:0] rc);
    n_chk++;
    if ({pll_rst, sys_rst, ready, fault, retry_cnt} !== {p, s, r, f, rc}) begin
      n_fail++;
      $display("FAIL %s: got pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d, want %b %b %b %b %0d",
               nm, pll_rst, sys_rst, ready, fault, retry_cnt, p, s, r, f, rc);
    end
  endtask

`ifdef PLL_LOCK_LOSS_CNT_EN
  task automatic chk_loss(input string nm, input int want);
    n_chk++;
    if (lock_loss_cnt !== 8'(want)) begin
      n_fail++;
      $display("FAIL %s: lock_loss_cnt=%0d want %0d", nm, lock_loss_cnt, want);
    end
  endtask
`endif

  typedef struct {
    int n;
    bit rst;
    bit lk;
    bit p;
    bit s;
    bit r;
    bit f;
    int rc;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int n_cyc;
    bit lvl;
    int len;

    rst    = 1'b1;
    locked = 1'b0;

    tbl[0]  = '{1, 1, 1, 1, 1, 0, 0, 0};
    tbl[1]  = '{3, 0, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 1, 0, 0, 0};
    tbl[3]  = '{20, 0, 1, 0, 1, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 0, 0, 1, 0, 0};
    tbl[5]  = '{2, 0, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{1, 0, 0, 1, 1, 0, 0, 0};
    tbl[7]  = '{3, 0, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{39, 0, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{1, 0, 0, 1, 1, 0, 0, 1};
    tbl[11] = '{4, 0, 0, 0, 1, 0, 0, 1};
    tbl[12] = '{40, 0, 0, 1, 1, 0, 0, 2};
    tbl[13] = '{4, 0, 0, 0, 1, 0, 0, 2};
    tbl[14] = '{40, 0, 0, 1, 1, 0, 0, 3};
    tbl[15] = '{4, 0, 0, 0, 1, 0, 0, 3};
    tbl[16] = '{40, 0, 0, 0, 1, 0, 1, 3};
    tbl[17] = '{10, 0, 1, 0, 1, 0, 1, 3};
    tbl[18] = '{1, 1, 1, 1, 1, 0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      rst    = tbl[i].rst;
      locked = tbl[i].lk;
      adv(tbl[i].n);
      chk($sformatf("tbl%0d", i), tbl[i].p, tbl[i].s, tbl[i].r,
          tbl[i].f, 4'(tbl[i].rc));
`ifdef PLL_LOCK_LOSS_CNT_EN
      if (i == 6) chk_loss("tbl_loss1", 1);
      if (i == 18) chk_loss("tbl_loss_rst", 0);
`endif
    end

    // Lock glitch sampled while in STABLE restarts qualification.
    rst = 1; locked = 1; tick(); rst = 0;
    adv(10);
    locked = 0; tick();
    locked = 1; adv(2);
    adv(12);
    chk("glitch_e25", 0, 1, 0, 0, 0);
    adv(8);
    chk("glitch_e33", 0, 1, 0, 0, 0);
    tick();
    chk("glitch_e34", 0, 0, 1, 0, 0);

    // rst pulse while in STABLE.
    rst = 1; tick(); rst = 0;
    adv(10);
    rst = 1; tick();
    chk("rst_in_stable", 1, 1, 0, 0, 0);
    rst = 0;
    adv(24);
    chk("restart_e24", 0, 1, 0, 0, 0);
    tick();
    chk("restart_e25", 0, 0, 1, 0, 0);

    // Lock arrives on the timeout cycle: STABLE wins, no retry.
    rst = 1; locked = 0; tick(); rst = 0;
    adv(41);
    locked = 1;
    adv(2);
    chk("coll_e43", 0, 1, 0, 0, 0);
    tick();
    chk("coll_e44", 0, 1, 0, 0, 0);
    adv(19);
    chk("coll_e63", 0, 1, 0, 0, 0);
    tick();
    chk("coll_e64", 0, 0, 1, 0, 0);

    // Randomized lock activity against the model.
    rst = 1; locked = 0; tick(); rst = 0;
    n_cyc = 0;
    while (n_cyc < 6000) begin
      lvl = ($urandom_range(0, 3) != 0);
      if (lvl) len = $urandom_range(5, 80);
      else if ($urandom_range(0, 4) == 0) len = $urandom_range(100, 260);
      else len = $urandom_range(1, 6);
      locked = lvl;
      for (int k = 0; k < len; k++) begin
        rst = ($urandom_range(0, 299) == 0);
        tick();
        n_cyc++;
        chk($sformatf("rand_c%0d", n_cyc), m_ph == RP, m_ph != RN,
            m_ph == RN, m_ph == FT, 4'(m_tries));
`ifdef PLL_LOCK_LOSS_CNT_EN
        chk_loss($sformatf("rand_loss_c%0d", n_cyc), m_loss);
`endif
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
